floor_request_scheduler: RTL and testbench
==========================================

# floor_request_scheduler

Upstream stage of the elevator controller. Latches hall/car call requests into a pending-floor set. Picks the next destination with a SCAN (keep-direction) policy and drives it as the controller's requested floor. Holds the door open for a dwell period on arrival, then serves the next request.

## Interface
- NUM_FLOORS, 10, number of served floors (0 .. NUM_FLOORS-1), max 16
- FLOOR_W, 4, floor index width
- DWELL_CYCLES, 10000000, door-open cycles per stop, ≥1
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- call_valid  in  1  one-cycle pulse, request for call_floor
- call_floor  in  FLOOR_W  requested floor; values ≥ NUM_FLOORS ignored
- current_floor  in  FLOOR_W  car position from controller
- car_idle  in  1  controller in IDLE state
- target_floor  out  FLOOR_W  destination to controller requested_floor
- target_valid  out  1  a stop is being served (SERVE state)
- door_open  out  1  high during DWELL
- dir_up  out  1  current SCAN direction, 1 = up
- pending  out  NUM_FLOORS  outstanding-request bitmask

## Operation
- Reset values: state IDLE, pending 0, target_floor 0, target_valid 0, door_open 0, dir_up 1, dwell counter 0.
- Call latch: on a valid in-range call_valid, set pending[call_floor] at the next edge, with two exceptions:
  - During DWELL, a call for target_floor restarts the dwell counter instead of setting the bit.
  - In the arrival cycle, a call for target_floor is absorbed; the clear wins.
- States:
  - IDLE: target_floor holds its last value. If pending ≠ 0, load the pick into target_floor, update dir_up, and go to SERVE.
  - SERVE: target_floor is locked and never retargeted. Arrival is car_idle && current_floor == target_floor. On arrival: clear pending[target_floor], load the dwell counter, go to DWELL.
  - DWELL: door_open = 1. Count down DWELL_CYCLES. Return to IDLE after the last cycle.
- SCAN pick, all comparisons unsigned:
  - If dir_up: the lowest pending floor ≥ current_floor. If none, set dir_up = 0 and take the highest pending floor < current_floor.
  - If !dir_up: the highest pending floor ≤ current_floor. If none, set dir_up = 1 and take the lowest pending floor > current_floor.
- A pending request at current_floor is picked, arrives in its first SERVE cycle, and opens the door without moving the car.
- There is no wrap-around. Floor indices never leave 0 .. NUM_FLOORS-1.
- Dwell counter width is clog2(DWELL_CYCLES+1).

## Timing
- Call pulse at edge N: pending bit is visible after edge N+1.
- Pending becomes nonzero in IDLE: target_floor and target_valid update at the following edge, 1 cycle latency.
- Arrival detected in cycle k: door_open is high from k+1 for exactly DWELL_CYCLES cycles, then IDLE. The next pick can be taken one cycle after returning to IDLE.
- The controller sees car_idle = 1 in the first SERVE cycle. The equality term prevents a false arrival unless the target really is current_floor.
- Reset asserted mid-move or mid-dwell: all state clears immediately. Pending requests are lost.
- Outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package elevator_pkg holds:
  - NUM_FLOORS, FLOOR_W
  - scheduler state encodings IDLE/SERVE/DWELL (2-bit)
  - the controller's state encodings, so both blocks agree.
- Sub-module scan_picker: purely combinational. Inputs pending, current_floor, dir_up. Outputs found, pick_floor, pick_dir_up. Instanced once, used in IDLE.

## Test plan
Bench uses DWELL_CYCLES=4 and a behavioural car model that moves one floor per 3 cycles toward target_floor.
- Reset, no calls: target_floor=0, target_valid=0, door_open=0, dir_up=1, pending=0 held for 20 cycles.
- Car at 0, call 5: pending=0x020 next cycle, target_floor=5 next cycle. Arrival at 5, door_open for exactly 4 cycles, pending=0.
- Car at 4 with dir_up, calls 2, 7, 6 in one burst: service order 6, 7, 2. dir_up flips to 0 on the third pick.
- Call at current floor 3 while IDLE: SERVE for 1 cycle, door_open 4 cycles, car never moves.
- Repeat call for floor 5 during dwell at 5: dwell restarts and lasts 4 cycles from the repeat. pending[5] stays 0.
- Out-of-range call_floor=12 ignored, pending unchanged. Reset mid-move toward 8: all outputs return to reset values at once.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller and its request scheduler:
// floor geometry, both blocks' state encodings, and a floor-to-bitmask helper.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 10;  // served floors 0 .. NUM_FLOORS-1, max 16
    localparam int unsigned FLOOR_W    = 4;   // floor index width

    // Scheduler states
    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_SERVE = 2'd1,
        SCHED_DWELL = 2'd2
    } sched_state_t;

    // Motion controller states, kept here so both blocks decode the same values
    typedef enum logic [1:0] {
        CTRL_IDLE      = 2'd0,
        CTRL_MOVE_UP   = 2'd1,
        CTRL_MOVE_DOWN = 2'd2,
        CTRL_DOOR      = 2'd3
    } ctrl_state_t;

    // One-hot pending-set mask for a floor; indices past the top floor give zero
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

endpackage

// File: rtl/floor_request_scheduler_scan_picker.sv
// SCAN destination picker: keeps the current direction while requests remain
// ahead of the car, otherwise reverses. Purely combinational.
module scan_picker
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    pick_floor,
    output logic                  pick_dir_up
);

    logic                 lo_ge_found, hi_lt_found, hi_le_found, lo_gt_found;
    logic [FLOOR_W-1:0]   lo_ge, hi_lt, hi_le, lo_gt;

    // Nearest pending floor on each side of the car (at/above, below, at/below, above)
    always_comb begin
        lo_ge_found = 1'b0;
        hi_lt_found = 1'b0;
        hi_le_found = 1'b0;
        lo_gt_found = 1'b0;
        lo_ge       = '0;
        hi_lt       = '0;
        hi_le       = '0;
        lo_gt       = '0;
        // Descending scan: the last hit is the lowest matching floor
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) >= current_floor)) begin
                lo_ge_found = 1'b1;
                lo_ge       = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
                lo_gt_found = 1'b1;
                lo_gt       = FLOOR_W'(i);
            end
        end
        // Ascending scan: the last hit is the highest matching floor
        for (int j = 0; j < int'(NUM_FLOORS); j++) begin
            if (pending[j] && (FLOOR_W'(j) < current_floor)) begin
                hi_lt_found = 1'b1;
                hi_lt       = FLOOR_W'(j);
            end
            if (pending[j] && (FLOOR_W'(j) <= current_floor)) begin
                hi_le_found = 1'b1;
                hi_le       = FLOOR_W'(j);
            end
        end
    end

    // Keep direction if something lies ahead, otherwise reverse
    always_comb begin
        found       = |pending;
        pick_floor  = '0;
        pick_dir_up = dir_up;
        if (dir_up) begin
            if (lo_ge_found) begin
                pick_floor  = lo_ge;
                pick_dir_up = 1'b1;
            end else if (hi_lt_found) begin
                pick_floor  = hi_lt;
                pick_dir_up = 1'b0;
            end
        end else begin
            if (hi_le_found) begin
                pick_floor  = hi_le;
                pick_dir_up = 1'b0;
            end else if (lo_gt_found) begin
                pick_floor  = lo_gt;
                pick_dir_up = 1'b1;
            end
        end
    end

endmodule

// File: rtl/floor_request_scheduler.sv
// Elevator request scheduler: latches hall/car calls into a pending set, picks
// the next stop with SCAN, holds it as target_floor until the car arrives, then
// keeps the door open for DWELL_CYCLES before serving the next stop.
//
// Call handshake: call_valid is a single-cycle pulse qualifying call_floor.
// There is no ready; every in-range call is accepted on the edge it is sampled,
// and out-of-range floors are silently dropped.
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 10000000
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output sched_state_t          fsm_state
);

    localparam int unsigned     CNT_W      = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);

    sched_state_t          state_next;
    logic [CNT_W-1:0]      dwell_cnt, dwell_cnt_next;
    logic [FLOOR_W-1:0]    target_next;
    logic                  dir_next;
    logic [NUM_FLOORS-1:0] pending_next, set_mask, clr_mask;

    logic                  pick_found;
    logic [FLOOR_W-1:0]    pick_floor;
    logic                  pick_dir_up;

    logic                  call_ok, call_is_target, arrival;

    assign call_ok        = call_valid && (32'(call_floor) < NUM_FLOORS);
    assign call_is_target = call_ok && (call_floor == target_floor);
    // car_idle alone is not enough: the controller is idle on the first SERVE cycle
    assign arrival        = (fsm_state == SCHED_SERVE) && car_idle &&
                            (current_floor == target_floor);

    scan_picker u_scan_picker (
        .pending       (pending),
        .current_floor (current_floor),
        .dir_up        (dir_up),
        .found         (pick_found),
        .pick_floor    (pick_floor),
        .pick_dir_up   (pick_dir_up)
    );

    // Next-state, next-target and pending-set update
    always_comb begin
        state_next     = fsm_state;
        target_next    = target_floor;
        dir_next       = dir_up;
        dwell_cnt_next = dwell_cnt;
        set_mask       = call_ok ? floor_mask(call_floor) : '0;
        clr_mask       = '0;
        case (fsm_state)
            SCHED_IDLE: begin
                if (pick_found) begin
                    target_next = pick_floor;
                    dir_next    = pick_dir_up;
                    state_next  = SCHED_SERVE;
                end
            end
            SCHED_SERVE: begin
                if (arrival) begin
                    // Clear wins over a same-cycle call for the floor being reached
                    clr_mask       = floor_mask(target_floor);
                    dwell_cnt_next = DWELL_LOAD;
                    state_next     = SCHED_DWELL;
                end
            end
            SCHED_DWELL: begin
                if (call_is_target) begin
                    // Someone pressed for this floor while the door is open: keep it open
                    set_mask       = '0;
                    dwell_cnt_next = DWELL_LOAD;
                end else if (dwell_cnt <= CNT_W'(1)) begin
                    dwell_cnt_next = '0;
                    state_next     = SCHED_IDLE;
                end else begin
                    dwell_cnt_next = dwell_cnt - 1'b1;
                end
            end
            default: begin
                state_next = SCHED_IDLE;
            end
        endcase
        pending_next = (pending | set_mask) & ~clr_mask;
    end

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state    <= SCHED_IDLE;
            pending      <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            door_open    <= 1'b0;
            dir_up       <= 1'b1;
            dwell_cnt    <= '0;
        end else begin
            fsm_state    <= state_next;
            pending      <= pending_next;
            target_floor <= target_next;
            target_valid <= (state_next == SCHED_SERVE);
            door_open    <= (state_next == SCHED_DWELL);
            dir_up       <= dir_next;
            dwell_cnt    <= dwell_cnt_next;
        end
    end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with a simple car model that moves
// one floor every 3 cycles toward target_floor while a stop is being served.
module tb_floor_request_scheduler;
    import elevator_pkg::*;

    localparam int unsigned DWELL = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  call_valid;
    logic [FLOOR_W-1:0]    call_floor;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  car_idle;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic                  door_open;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    sched_state_t          fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    int move_cnt = 0;

    logic [FLOOR_W-1:0] exp_q[$];
    logic               exp_dir_q[$];

    floor_request_scheduler #(.DWELL_CYCLES(DWELL)) dut (
        .clk           (clk),
        .reset         (reset),
        .call_valid    (call_valid),
        .call_floor    (call_floor),
        .current_floor (current_floor),
        .car_idle      (car_idle),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .door_open     (door_open),
        .dir_up        (dir_up),
        .pending       (pending),
        .fsm_state     (fsm_state)
    );

    // Clock
    initial forever #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: advance past the edge, then step the car model
    task automatic cycle();
        @(posedge clk);
        #1;
        if (target_valid && (current_floor != target_floor)) begin
            move_cnt++;
            if (move_cnt == 3) begin
                move_cnt = 0;
                if (target_floor > current_floor) current_floor = current_floor + 1'b1;
                else                              current_floor = current_floor - 1'b1;
            end
        end else begin
            move_cnt = 0;
        end
        car_idle = !(target_valid && (current_floor != target_floor));
    endtask

    task automatic teleport(input logic [FLOOR_W-1:0] f);
        current_floor = f;
        move_cnt      = 0;
        car_idle      = 1'b1;
    endtask

    task automatic call(input logic [FLOOR_W-1:0] f);
        call_valid = 1'b1;
        call_floor = f;
        cycle();
        call_valid = 1'b0;
        call_floor = '0;
    endtask

    // Wait for the next door opening (any current dwell is allowed to finish first)
    task automatic wait_stop();
        int b;
        b = 0;
        while (door_open && b < 200) begin
            cycle();
            b++;
        end
        while (!door_open && b < 400) begin
            cycle();
            b++;
        end
        check("stop_seen", 32'(door_open), 32'h1);
    endtask

    // Number of consecutive door-open cycles starting with the current one
    task automatic count_door(output int n);
        n = 0;
        while (door_open && n < 100) begin
            n++;
            cycle();
        end
    endtask

    initial begin
        int n;
        logic [FLOOR_W-1:0] exp_f;
        logic               exp_d;

        // Reset
        reset         = 1'b1;
        call_valid    = 1'b0;
        call_floor    = '0;
        current_floor = '0;
        car_idle      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 32'({target_floor, target_valid, door_open, dir_up, pending}),
              32'({4'd0, 1'b0, 1'b0, 1'b1, 10'd0}));
        check("rst_state", 32'(fsm_state), 32'(SCHED_IDLE));
        reset = 1'b0;

        // No calls: everything holds its reset value
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("idle_hold", 32'({target_floor, target_valid, door_open, dir_up, pending}),
                  32'({4'd0, 1'b0, 1'b0, 1'b1, 10'd0}));
        end

        // Car at 0, call 5
        call(4'd5);
        check("c5_pending", 32'(pending), 32'h020);
        check("c5_tv_early", 32'(target_valid), 32'h0);
        cycle();
        check("c5_target", 32'(target_floor), 32'h5);
        check("c5_tv", 32'(target_valid), 32'h1);
        check("c5_dir", 32'(dir_up), 32'h1);
        wait_stop();
        check("c5_arrive_pos", 32'(current_floor), 32'h5);
        check("c5_pending_clr", 32'(pending), 32'h0);
        count_door(n);
        check("c5_dwell_len", 32'(n), 32'(DWELL));
        check("c5_back_idle", 32'(fsm_state), 32'(SCHED_IDLE));

        // Car at 4 going up; burst of calls 2, 7, 6 while the door is open at 4
        teleport(4'd4);
        call(4'd4);
        wait_stop();
        call(4'd2);
        call(4'd7);
        call(4'd6);
        check("burst_pending", 32'(pending), 32'h0C4);
        check("burst_door_held", 32'(door_open), 32'h1);
        exp_q.push_back(4'd6); exp_dir_q.push_back(1'b1);
        exp_q.push_back(4'd7); exp_dir_q.push_back(1'b1);
        exp_q.push_back(4'd2); exp_dir_q.push_back(1'b0);
        while (exp_q.size() > 0) begin
            exp_f = exp_q.pop_front();
            exp_d = exp_dir_q.pop_front();
            wait_stop();
            check("order_target", 32'(target_floor), 32'(exp_f));
            check("order_pos", 32'(current_floor), 32'(exp_f));
            check("order_dir", 32'(dir_up), 32'(exp_d));
        end
        count_door(n);
        check("burst_last_dwell", 32'(n), 32'(DWELL));
        check("burst_pending_end", 32'(pending), 32'h0);

        // Call at the current floor 3 while idle: one SERVE cycle, no motion
        teleport(4'd3);
        call(4'd3);
        check("here_pending", 32'(pending), 32'h008);
        check("here_tv_early", 32'(target_valid), 32'h0);
        cycle();
        check("here_serve", 32'({target_valid, door_open, target_floor}), 32'({1'b1, 1'b0, 4'd3}));
        cycle();
        check("here_door", 32'({target_valid, door_open}), 32'({1'b0, 1'b1}));
        check("here_dir", 32'(dir_up), 32'h0);
        count_door(n);
        check("here_dwell_len", 32'(n), 32'(DWELL));

        // Repeat call for 5 during the dwell at 5 restarts the dwell
        teleport(4'd5);
        call(4'd5);
        wait_stop();
        cycle();
        call(4'd5);
        check("rep_pending", 32'(pending), 32'h0);
        check("rep_door", 32'(door_open), 32'h1);
        count_door(n);
        check("rep_dwell_len", 32'(n), 32'(DWELL));
        check("rep_pending_end", 32'(pending), 32'h0);

        // Out-of-range calls are dropped
        call(4'd12);
        check("oor12_pending", 32'(pending), 32'h0);
        cycle();
        check("oor12_tv", 32'(target_valid), 32'h0);
        call(4'd10);
        check("oor10_pending", 32'(pending), 32'h0);

        // Move toward 8 (reverses to up from 5), then reset mid-move
        call(4'd8);
        check("c8_pending", 32'(pending), 32'h100);
        cycle();
        check("c8_target", 32'({target_valid, target_floor}), 32'({1'b1, 4'd8}));
        check("c8_dir", 32'(dir_up), 32'h1);
        repeat (4) cycle();
        check("c8_moving", 32'({target_valid, door_open}), 32'({1'b1, 1'b0}));
        reset = 1'b1;
        #1;
        check("async_rst_outputs", 32'({target_floor, target_valid, door_open, dir_up, pending}),
              32'({4'd0, 1'b0, 1'b0, 1'b1, 10'd0}));
        check("async_rst_state", 32'(fsm_state), 32'(SCHED_IDLE));
        cycle();
        reset = 1'b0;
        teleport(4'd0);

        // Top floor is accepted
        call(4'd9);
        check("c9_pending", 32'(pending), 32'h200);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
